generate_proof_deadlock_reporter: RTL

//  Consumes the 1-bit 'block' output of the top-level GenerateProof deadlock monitor (idx0). Qualifies it
//  by a persistence threshold, latches a sticky deadlock flag and snapshots the raw axis/inst block vectors

---
 rtl/generate_proof_deadlock_reporter_pkg.sv | 25 ++
 rtl/generate_proof_deadlock_reporter_if.sv | 13 +
 rtl/generate_proof_deadlock_reporter_persist.sv | 36 +++
 rtl/generate_proof_deadlock_reporter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/generate_proof_deadlock_reporter_pkg.sv
// Shared types and default widths for the GenerateProof deadlock reporter.
// The report word is {timestamp, axis snapshot, instance snapshot}.
package gp_dbg_pkg;

   localparam int unsigned DEF_THRESHOLD = 16;
   localparam int unsigned DEF_TS_W      = 32;
   localparam int unsigned DEF_AXIS_W    = 8;
   localparam int unsigned DEF_INST_W    = 11;
   localparam int unsigned DEF_EVT_W     = 8;
   localparam int unsigned REPORT_W      = DEF_TS_W + DEF_AXIS_W + DEF_INST_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_REPORT = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

   function automatic int unsigned report_width(input int unsigned ts_w,
                                                input int unsigned axis_w,
                                                input int unsigned inst_w);
      return ts_w + axis_w + inst_w;
   endfunction

endpackage

// File: rtl/generate_proof_deadlock_reporter_if.sv
// Valid/ready report channel from the deadlock reporter to the debug sink.
interface generate_proof_deadlock_reporter_if #(
   parameter int unsigned DATA_W = gp_dbg_pkg::REPORT_W
) ();

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/generate_proof_deadlock_reporter_persist.sv
// Saturating run-length counter of consecutive block=1 samples; hit flags the
// edge on which the run reaches (or sits at) THRESHOLD.
module gp_persist_counter #(
   parameter int unsigned THRESHOLD = gp_dbg_pkg::DEF_THRESHOLD
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic block,
   output logic hit
);

   localparam int unsigned CNT_W = $clog2(THRESHOLD + 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc_c;

   always_comb begin
      count_inc_c = '0;
      if (block) begin
         count_inc_c = (count == CNT_W'(THRESHOLD)) ? count : count + CNT_W'(1);
      end
      hit = block && (count_inc_c == CNT_W'(THRESHOLD));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else begin
         count <= count_inc_c;
      end
   end

endmodule

// File: rtl/generate_proof_deadlock_reporter.sv
// Qualifies the idx0 deadlock monitor's block output by persistence, latches a
// sticky flag and emits one timestamped snapshot report per episode.
module generate_proof_deadlock_reporter
   import gp_dbg_pkg::*;
#(
   parameter int unsigned THRESHOLD = DEF_THRESHOLD,
   parameter int unsigned TS_W      = DEF_TS_W,
   parameter int unsigned AXIS_W    = DEF_AXIS_W,
   parameter int unsigned INST_W    = DEF_INST_W,
   parameter int unsigned EVT_W     = DEF_EVT_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                block,
   input  logic [AXIS_W-1:0]   axis_block_sigs,
   input  logic [INST_W-1:0]   inst_block_sigs,
   input  logic                clr,
   generate_proof_deadlock_reporter_if.master report,
   output logic                deadlock_flag,
   output logic [EVT_W-1:0]    event_count
);

   localparam int unsigned REP_W = report_width(TS_W, AXIS_W, INST_W);

   state_e             state;
   state_e             state_next;
   logic               capture_c;
   logic               hit;
   logic               valid;
   logic [REP_W-1:0]   data;
   logic [TS_W-1:0]    timestamp;

   assign report.valid = valid;
   assign report.data  = data;

   gp_persist_counter #(
      .THRESHOLD (THRESHOLD)
   ) u_persist (
      .clock (clock),
      .reset (reset),
      .clr   (clr),
      .block (block),
      .hit   (hit)
   );

   // Free-running timestamp; clr deliberately leaves it alone.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timestamp <= '0;
      end else begin
         timestamp <= timestamp + TS_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; clr overrides everything including a coincident hit.
   always_comb begin
      state_next = state;
      capture_c  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (block) begin
               state_next = hit ? ST_REPORT : ST_COUNT;
               capture_c  = hit;
            end
         end
         ST_COUNT: begin
            if (!block) begin
               state_next = ST_IDLE;
            end else if (hit) begin
               state_next = ST_REPORT;
               capture_c  = 1'b1;
            end
         end
         ST_REPORT: begin
            if (report.ready) begin
               state_next = block ? ST_HOLD : ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (!block) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (clr) begin
         state_next = ST_IDLE;
         capture_c  = 1'b0;
      end
   end

   // Report word, sticky flag and saturating episode counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid         <= 1'b0;
         data          <= '0;
         deadlock_flag <= 1'b0;
         event_count   <= '0;
      end else begin
         valid <= (state_next == ST_REPORT);
         if (capture_c) begin
            data          <= {timestamp, axis_block_sigs, inst_block_sigs};
            deadlock_flag <= 1'b1;
            if (event_count != {EVT_W{1'b1}}) begin
               event_count <= event_count + EVT_W'(1);
            end
         end
         if (clr) begin
            deadlock_flag <= 1'b0;
            event_count   <= '0;
         end
      end
   end

endmodule
